// File: rtl/param_data_memory_if.sv
// ---------------------------------------------------------------------------
// param_data_memory_if
//
// Bus bundle between a datapath (master) and param_data_memory (slave).
//
// Signals:
//   MemWrite  master->slave  write request, sampled at the rising edge
//   MemRead   master->slave  read request, sampled at the rising edge
//   Address   master->slave  word address (ADDR_WIDTH bits)
//   WriteData master->slave  write data (DATA_WIDTH bits)
//   ReadData  slave->master  registered read data
//   ReadValid slave->master  one-cycle strobe, ReadData updated by a read
//   Busy      slave->master  high during reset and the init sweep
//   AddrError slave->master  one-cycle strobe, request had Address >= DEPTH
// ---------------------------------------------------------------------------
interface param_data_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  MemWrite;
    logic                  MemRead;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  ReadValid;
    logic                  Busy;
    logic                  AddrError;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, ReadValid, Busy, AddrError
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, ReadValid, Busy, AddrError
    );
endinterface

// File: rtl/param_data_memory.sv
// ---------------------------------------------------------------------------
// param_data_memory
//
// Parametrised data memory for the datapath. Reads are registered and come
// back one cycle later with a ReadValid strobe; writes land on the sampling
// edge. After reset an INIT state sweeps the array one word per edge while
// Busy is high, then RUN accepts requests. Addresses >= DEPTH are flagged
// with AddrError instead of aliasing onto real words.
//
// Ports:
//   CLK    input  single clock, rising edge
//   reset  input  synchronous, active-high reset
//   bus    slave  modport of param_data_memory_if (requests and responses)
//
// Parameters: DATA_WIDTH (word width), ADDR_WIDTH (address width),
//             DEPTH (word count, even, 2 .. 2**ADDR_WIDTH).
//
// Build option: define DMEM_INIT_PATTERN_EN to fill the array with a ramp
// (lower half) and negated ramp (upper half) during the sweep; otherwise the
// sweep writes zeros. Sweep timing is the same either way.
// ---------------------------------------------------------------------------
module param_data_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 32
) (
    input logic                CLK,
    input logic                reset,
    param_data_memory_if.slave bus
);
    localparam int IDX_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int AEXT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(DEPTH - 1);
    localparam logic [AEXT_WIDTH-1:0] DEPTH_EXT = AEXT_WIDTH'(DEPTH);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                state;
    logic [IDX_WIDTH-1:0]  sweepIdx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  inRange;
    logic [IDX_WIDTH-1:0]  wordAddr;
    logic [DATA_WIDTH-1:0] initWord;
    logic                  memWe;
    logic [IDX_WIDTH-1:0]  memWAddr;
    logic [DATA_WIDTH-1:0] memWData;

    // The extra leading bit lets DEPTH == 2**ADDR_WIDTH compare correctly.
    assign inRange  = {1'b0, bus.Address} < DEPTH_EXT;
    assign wordAddr = bus.Address[IDX_WIDTH-1:0];

`ifdef DMEM_INIT_PATTERN_EN
    localparam logic [IDX_WIDTH-1:0] HALF_IDX = IDX_WIDTH'(DEPTH / 2);

    // Lower half holds its own index, upper half holds the negated offset
    // from the midpoint, wrapped to the word width.
    always_comb begin
        initWord = DATA_WIDTH'(sweepIdx);
        if (sweepIdx >= HALF_IDX) begin
            initWord = DATA_WIDTH'(0) - DATA_WIDTH'(sweepIdx - HALF_IDX);
        end
    end
`else
    assign initWord = '0;
`endif

    // Single write port shared by the sweep and accepted writes. Nothing is
    // written on a reset edge, and out-of-range writes never reach the array.
    always_comb begin
        memWe    = 1'b0;
        memWAddr = sweepIdx;
        memWData = initWord;
        if (!reset) begin
            if (state == INIT) begin
                memWe = 1'b1;
            end else begin
                memWe    = bus.MemWrite && inRange;
                memWAddr = wordAddr;
                memWData = bus.WriteData;
            end
        end
    end

    // Array storage kept free of reset so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[memWAddr] <= memWData;
        end
    end

    // Control FSM with registered outputs. Reads sample the array before the
    // write port updates it, which gives read-before-write on a same-address
    // read+write. Requests during INIT are dropped without any strobe.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= INIT;
            sweepIdx      <= '0;
            bus.ReadData  <= '0;
            bus.ReadValid <= 1'b0;
            bus.AddrError <= 1'b0;
            bus.Busy      <= 1'b1;
        end else if (state == INIT) begin
            bus.ReadValid <= 1'b0;
            bus.AddrError <= 1'b0;
            if (sweepIdx == LAST_IDX) begin
                state    <= RUN;
                sweepIdx <= '0;
                bus.Busy <= 1'b0;
            end else begin
                sweepIdx <= sweepIdx + 1'b1;
                bus.Busy <= 1'b1;
            end
        end else begin
            bus.Busy      <= 1'b0;
            bus.ReadValid <= bus.MemRead;
            bus.AddrError <= (bus.MemRead || bus.MemWrite) && !inRange;
            if (bus.MemRead) begin
                bus.ReadData <= inRange ? mem[wordAddr] : '0;
            end
        end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// ---------------------------------------------------------------------------
// tb_param_data_memory
//
// Self-checking bench for param_data_memory with default parameters
// (8-bit words, 8-bit address, 32 words). Inputs are driven and outputs
// sampled on the falling clock edge. Expected init contents follow the
// DMEM_INIT_PATTERN_EN build option.
// ---------------------------------------------------------------------------
module tb_param_data_memory;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 32;

    logic CLK;
    logic reset;

    param_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_data_memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string     name;
        logic      we;
        logic      re;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic      expValid;
        logic      expErr;
        logic [7:0] expData;
    } vec_t;

    int passCount = 0;
    int checkCount = 0;

    logic [7:0] modelMem [DEPTH];
    logic [7:0] lastData;

    // Initial word contents as defined for the sweep.
    function automatic logic [7:0] initVal(int i);
`ifdef DMEM_INIT_PATTERN_EN
        if (i < DEPTH / 2) return 8'(i);
        return 8'(-(i - DEPTH / 2));
`else
        return 8'(i * 0);
`endif
    endfunction

    function automatic vec_t mkVec(string n, logic we, logic re, logic [7:0] a,
                                   logic [7:0] wd, logic ev, logic ee,
                                   logic [7:0] ed);
        vec_t v;
        v.name = n; v.we = we; v.re = re; v.addr = a; v.wdata = wd;
        v.expValid = ev; v.expErr = ee; v.expData = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(logic we, logic re, logic [7:0] a, logic [7:0] wd);
        bus.MemWrite  = we;
        bus.MemRead   = re;
        bus.Address   = a;
        bus.WriteData = wd;
    endtask

    // One request through the DUT, predicted from the array model.
    task automatic applyStimulus(logic we, logic re, logic [7:0] a, logic [7:0] wd);
        logic expErr;
        driveInputs(we, re, a, wd);
        step();
        expErr = (we || re) && (a >= DEPTH);
        if (re) lastData = (a < DEPTH) ? modelMem[a] : 8'h00;
        checkOutput("rdValid", 32'(bus.ReadValid), 32'(re));
        checkOutput("addrErr", 32'(bus.AddrError), 32'(expErr));
        checkOutput("rdData", 32'(bus.ReadData), 32'(lastData));
        if (we && a < DEPTH) modelMem[a] = wd;
    endtask

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) modelMem[i] = initVal(i);
        lastData = 8'h00;
    endtask

    // Runs the sweep with random requests thrown at the DUT; none of them
    // may produce a strobe. Returns the number of edges until Busy drops.
    task automatic runSweep(output int edges);
        edges = 0;
        for (int n = 0; n < 100; n++) begin
            driveInputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 47)), 8'($urandom));
            step();
            edges++;
            checkOutput("sweepValid", 32'(bus.ReadValid), 32'd0);
            checkOutput("sweepErr", 32'(bus.AddrError), 32'd0);
            checkOutput("sweepData", 32'(bus.ReadData), 32'd0);
            if (!bus.Busy) break;
        end
        driveInputs(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic checkResetState(string tag);
        checkOutput({tag, "Busy"}, 32'(bus.Busy), 32'd1);
        checkOutput({tag, "Valid"}, 32'(bus.ReadValid), 32'd0);
        checkOutput({tag, "Err"}, 32'(bus.AddrError), 32'd0);
        checkOutput({tag, "Data"}, 32'(bus.ReadData), 32'd0);
    endtask

    initial begin
        vec_t vecs [13];
        int edges;

        reset = 1'b1;
        driveInputs(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step();
        checkResetState("reset");

        // Partial sweep, then reset at sweep index 10 with requests pending.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            driveInputs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        8'($urandom_range(0, 31)), 8'($urandom));
            step();
            checkOutput("partialBusy", 32'(bus.Busy), 32'd1);
            checkOutput("partialValid", 32'(bus.ReadValid), 32'd0);
        end
        reset = 1'b1;
        driveInputs(1'b1, 1'b1, 8'h00, 8'hEE);
        step();
        checkResetState("midSweepReset");
        reset = 1'b0;
        runSweep(edges);
        checkOutput("sweepLen", 32'(edges), 32'd32);
        resetModel();

        // Directed vectors after a clean sweep.
        vecs[0]  = mkVec("rd0",    0, 1, 8'd0,  8'h00, 1, 0, initVal(0));
        vecs[1]  = mkVec("rd15",   0, 1, 8'd15, 8'h00, 1, 0, initVal(15));
        vecs[2]  = mkVec("rd16",   0, 1, 8'd16, 8'h00, 1, 0, initVal(16));
        vecs[3]  = mkVec("rd17",   0, 1, 8'd17, 8'h00, 1, 0, initVal(17));
        vecs[4]  = mkVec("rd31",   0, 1, 8'd31, 8'h00, 1, 0, initVal(31));
        vecs[5]  = mkVec("wr7",    1, 0, 8'd7,  8'hA5, 0, 0, initVal(31));
        vecs[6]  = mkVec("rd7",    0, 1, 8'd7,  8'h00, 1, 0, 8'hA5);
        vecs[7]  = mkVec("rw3",    1, 1, 8'd3,  8'h3C, 1, 0, initVal(3));
        vecs[8]  = mkVec("rd3",    0, 1, 8'd3,  8'h00, 1, 0, 8'h3C);
        vecs[9]  = mkVec("wr40",   1, 0, 8'd40, 8'h11, 0, 1, 8'h3C);
        vecs[10] = mkVec("rd40",   0, 1, 8'd40, 8'h00, 1, 1, 8'h00);
        vecs[11] = mkVec("idle",   0, 0, 8'd9,  8'h77, 0, 0, 8'h00);
        vecs[12] = mkVec("rd8",    0, 1, 8'd8,  8'h00, 1, 0, initVal(8));

        for (int i = 0; i < 13; i++) begin
            driveInputs(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            step();
            checkOutput({vecs[i].name, "/valid"}, 32'(bus.ReadValid), 32'(vecs[i].expValid));
            checkOutput({vecs[i].name, "/err"}, 32'(bus.AddrError), 32'(vecs[i].expErr));
            checkOutput({vecs[i].name, "/data"}, 32'(bus.ReadData), 32'(vecs[i].expData));
        end
        modelMem[7] = 8'hA5;
        modelMem[3] = 8'h3C;
        lastData    = initVal(8);

        // Full readback: only words 3 and 7 differ from the init contents.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'(i), 8'h00);

        // Random traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 47)), 8'($urandom));
        end

        // Reset in the middle of operation restarts the sweep.
        reset = 1'b1;
        driveInputs(1'b1, 1'b1, 8'd5, 8'h99);
        step();
        checkResetState("runReset");
        reset = 1'b0;
        runSweep(edges);
        checkOutput("sweepLen2", 32'(edges), 32'd32);
        resetModel();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 8'(i), 8'h00);
        driveInputs(1'b0, 1'b0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
